sc_spi_tgt: RTL

SPI target (slave) protocol engine: the far end of the SPI master engine on the same four-wire bus. It oversamples CSB/SCLK/MOSI in the SPICLK domain, deserialises MOSI into words and serialises TXDATA onto MISO. It uses the same TXDETECT/RXVALID toggle handshake and byte-order rules as the master engine, so both share register-level glue.

---
 rtl/sc_spi_pkg.sv | 21 ++
 rtl/sc_spi_sync.sv | 31 +++
 rtl/sc_spi_tgt.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/sc_spi_pkg.sv
// rtl/sc_spi_pkg.sv - shared SPI state encodings, edge-select constants and bit-position helper
package sc_spi_pkg;

   typedef enum logic [1:0] {
      tgtSYNC = 2'd0,
      tgtIDLE = 2'd1,
      tgtDATA = 2'd2
   } tgt_state_t;

   localparam logic CPOL_IDLE_LOW    = 1'b0;
   localparam logic CPHA_SAMPLE_LEAD = 1'b0;

   // Byte-ordered placement only makes sense for whole bytes; other widths fall back to MSB-first.
   function automatic logic [4:0] bpos(input logic border, input logic [4:0] bc, input logic [4:0] dwidth);
      if (border && (dwidth[2:0] == 3'b111))
         bpos = {bc[4:3], 3'b000} + (5'd7 - {2'b00, bc[2:0]});
      else
         bpos = dwidth - bc;
   endfunction

endpackage

// File: rtl/sc_spi_sync.sv
// rtl/sc_spi_sync.sv - multi-flop synchroniser with level, rise and fall outputs
module sc_spi_sync #(
   parameter int STAGES = 2
) (
   input  logic SPICLK,
   input  logic SYSRSTB,
   input  logic pin,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;

   // Resetting to 0 makes CSB look asserted, so the engine never trusts a stale high level.
   always_ff @(posedge SPICLK or negedge SYSRSTB) begin
      if (!SYSRSTB) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], pin};
         prev_q <= sync_q[STAGES-1];
      end
   end

   assign level = sync_q[STAGES-1];
   assign rise  = level & ~prev_q;
   assign fall  = ~level & prev_q;

endmodule

// File: rtl/sc_spi_tgt.sv
// rtl/sc_spi_tgt.sv - SPI target protocol engine (oversampled, SPICLK domain)
// Byte-order support is built only when SC_SPI_TGT_BORDER_EN is defined.
module sc_spi_tgt
   import sc_spi_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic        SPICLK,
   input  logic        SYSRSTB,
   input  logic        CPOL,
   input  logic        CPHA,
   input  logic [4:0]  DWIDTH,
   input  logic        BORDER,
   input  logic [31:0] TXDATA,
   output logic        TXDETECT,
   output logic [31:0] RXDATA,
   output logic        RXVALID,
   output logic        SPIBUSY,
   output logic        FRMERR,
   input  logic        CSB,
   input  logic        SCLK,
   input  logic        MOSI,
   output logic        MISO,
   output logic        MISOEN
);

   logic csb_lvl, csb_rise, csb_fall;
   logic sclk_lvl_unused, sclk_rise, sclk_fall;
   logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;

   sc_spi_sync #(.STAGES(SYNC_STAGES)) u_sync_csb (
      .SPICLK(SPICLK), .SYSRSTB(SYSRSTB), .pin(CSB),
      .level(csb_lvl), .rise(csb_rise), .fall(csb_fall)
   );

   sc_spi_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
      .SPICLK(SPICLK), .SYSRSTB(SYSRSTB), .pin(SCLK),
      .level(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall)
   );

   sc_spi_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
      .SPICLK(SPICLK), .SYSRSTB(SYSRSTB), .pin(MOSI),
      .level(mosi_lvl), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
   );

   logic border_eff;
`ifdef SC_SPI_TGT_BORDER_EN
   assign border_eff = BORDER;
`else
   logic border_unused;
   assign border_unused = BORDER;
   assign border_eff    = 1'b0;
`endif

   tgt_state_t  state_q, state_d;
   logic [4:0]  bc_q;
   logic        sampled_q;
   logic [31:0] tx_q;
   logic [31:0] rx_q;

   logic        lead_edge, trail_edge, sample_edge, shift_edge;
   logic        frame_start, frame_end, word_done;
   logic [4:0]  bit_pos, first_pos;
   logic [31:0] rx_merged;

   always_comb begin
      lead_edge   = (CPOL == CPOL_IDLE_LOW) ? sclk_rise : sclk_fall;
      trail_edge  = (CPOL == CPOL_IDLE_LOW) ? sclk_fall : sclk_rise;
      sample_edge = (CPHA == CPHA_SAMPLE_LEAD) ? lead_edge : trail_edge;
      shift_edge  = (CPHA == CPHA_SAMPLE_LEAD) ? trail_edge : lead_edge;
      bit_pos     = bpos(border_eff, bc_q, DWIDTH);
      first_pos   = bpos(border_eff, 5'd0, DWIDTH);
      word_done   = (bc_q == DWIDTH);
      rx_merged   = rx_q;
      rx_merged[bit_pos] = mosi_lvl;
   end

   always_ff @(posedge SPICLK or negedge SYSRSTB) begin
      if (!SYSRSTB)
         state_q <= tgtSYNC;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      frame_start = 1'b0;
      frame_end   = 1'b0;
      case (state_q)
         tgtSYNC: if (csb_lvl) state_d = tgtIDLE;
         tgtIDLE: if (csb_fall) begin
            state_d     = tgtDATA;
            frame_start = 1'b1;
         end
         tgtDATA: if (csb_rise) begin
            state_d   = tgtIDLE;
            frame_end = 1'b1;
         end
         default: state_d = tgtSYNC;
      endcase
   end

   always_ff @(posedge SPICLK or negedge SYSRSTB) begin
      if (!SYSRSTB) begin
         bc_q      <= '0;
         sampled_q <= 1'b0;
         tx_q      <= '0;
         rx_q      <= '0;
         TXDETECT  <= 1'b0;
         RXDATA    <= '0;
         RXVALID   <= 1'b0;
         SPIBUSY   <= 1'b0;
         FRMERR    <= 1'b0;
         MISO      <= 1'b0;
         MISOEN    <= 1'b0;
      end else begin
         FRMERR <= 1'b0;
         if (frame_start) begin
            tx_q      <= TXDATA;
            TXDETECT  <= ~TXDETECT;
            bc_q      <= '0;
            sampled_q <= 1'b0;
            rx_q      <= '0;
            SPIBUSY   <= 1'b1;
            MISOEN    <= 1'b1;
            MISO      <= TXDATA[first_pos];
         end else if (frame_end) begin
            // CSB rise outranks a coincident sample edge; a partial word is dropped.
            SPIBUSY <= 1'b0;
            MISOEN  <= 1'b0;
            MISO    <= 1'b0;
            bc_q    <= '0;
            rx_q    <= '0;
            FRMERR  <= (bc_q != 5'd0);
         end else if (state_q == tgtDATA) begin
            if (sample_edge) begin
               sampled_q <= 1'b1;
               if (word_done) begin
                  RXDATA   <= rx_merged;
                  RXVALID  <= ~RXVALID;
                  bc_q     <= '0;
                  rx_q     <= '0;
                  tx_q     <= TXDATA;
                  TXDETECT <= ~TXDETECT;
               end else begin
                  rx_q <= rx_merged;
                  bc_q <= bc_q + 5'd1;
               end
            end else if (shift_edge && (CPHA != CPHA_SAMPLE_LEAD || sampled_q)) begin
               MISO <= tx_q[bit_pos];
            end
         end
      end
   end

endmodule
